// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage (master) and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int WIDTH = 64
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ready;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake with one-entry hold buffer, IF/ID register.
// Optional macro FETCH_PERF_CNT_EN adds FetchCountF/BubbleCountF performance counters.
module fetch_stage #(
    parameter int               WIDTH       = 64,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               INSTR_BYTES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              BranchTakenE,
    input  logic [WIDTH-1:0]  BranchTargetE,
    input  logic              PCSrcW,
    input  logic [WIDTH-1:0]  ResultW,
    fetch_stage_if.master     imem,
    output logic [WIDTH-1:0]  InstructionD,
    output logic [WIDTH-1:0]  PCPlus8D,
    output logic              ValidD
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       FetchCountF,
    output logic [31:0]       BubbleCountF
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             kill_q, kill_d;
    logic [WIDTH-1:0] hold_data_q, hold_pc8_q;
    logic             hold_load;

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc8_q, pc8_d;
    logic             valid_q, valid_d;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;
    logic             handshake;
    logic             deliver;
    logic [WIDTH-1:0] deliver_data;
    logic [WIDTH-1:0] deliver_pc8;

    // Writeback redirect belongs to the older instruction, so it outranks Execute.
    assign redirect  = PCSrcW | BranchTakenE;
    assign target    = PCSrcW ? ResultW : BranchTargetE;
    assign pc_inc    = pc_q + WIDTH'(INSTR_BYTES);

    assign imem.imem_req  = (state_q == S_REQ) & ~reset;
    assign imem.imem_addr = pc_q;
    assign handshake      = imem.imem_req & imem.imem_ready;

    assign InstructionD = instr_q;
    assign PCPlus8D     = pc8_q;
    assign ValidD       = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        hold_load    = 1'b0;
        deliver      = 1'b0;
        deliver_data = imem.imem_rdata;
        deliver_pc8  = pc_inc;
        case (state_q)
            S_REQ: begin
                if (redirect) pc_d = target;
                if (handshake) begin
                    state_d = S_WAIT;
                    kill_d  = redirect;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = target;
                    if (imem.imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem.imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!StallD) begin
                        deliver = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_REQ;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (!StallD) begin
                    deliver      = 1'b1;
                    deliver_data = hold_data_q;
                    deliver_pc8  = hold_pc8_q;
                    pc_d         = pc_inc;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // A bubble keeps PCPlus8D so the last link value stays observable.
    always_comb begin
        instr_d = instr_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (!StallD) begin
            if (FlushD || redirect || !deliver) begin
                instr_d = '0;
                valid_d = 1'b0;
            end else begin
                instr_d = deliver_data;
                pc8_d   = deliver_pc8;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            instr_q <= '0;
            pc8_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            instr_q <= instr_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
        end
    end

    // Buffer contents are only meaningful in S_HOLD, so they need no reset.
    always_ff @(posedge clk) begin
        if (hold_load) begin
            hold_data_q <= imem.imem_rdata;
            hold_pc8_q  <= pc_inc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else if (!StallD) begin
            if (valid_d) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            else         bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign FetchCountF  = fetch_cnt_q;
    assign BubbleCountF = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by randomized traffic against a program-order model.
module tb_fetch_stage;

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk;
    logic        reset;
    logic        StallD, FlushD, BranchTakenE, PCSrcW;
    logic [63:0] BranchTargetE, ResultW;
    logic [63:0] InstructionD, PCPlus8D;
    logic        ValidD;

    fetch_stage_if #(.WIDTH(64)) imem_bus ();

    fetch_stage #(.WIDTH(64), .RESET_PC(64'h0), .INSTR_BYTES(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .PCSrcW        (PCSrcW),
        .ResultW       (ResultW),
        .imem          (imem_bus),
        .InstructionD  (InstructionD),
        .PCPlus8D      (PCPlus8D),
        .ValidD        (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rst, stall, flush, br, brt, pcsrc, res, rdy, rv, rdata;
        logic [63:0] chk, ereq, eaddr, evalid, einstr, epc8;
    } vec_t;

    vec_t vecs[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic row(input logic [63:0] rst, stall, flush, br, brt, pcsrc, res, rdy, rv, rdata,
                       input logic [63:0] chk, ereq, eaddr, evalid, einstr, epc8);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.br = br; v.brt = brt;
        v.pcsrc = pcsrc; v.res = res; v.rdy = rdy; v.rv = rv; v.rdata = rdata;
        v.chk = chk; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid;
        v.einstr = einstr; v.epc8 = epc8;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory contents: a word derived from its own address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
    endfunction

    // Random-phase state
    logic [63:0] exp_pc, m_addr, prv_tgt, prv_addr, p_instr, p_pc8, tgt;
    logic        p_valid, prv_stall, prv_redir, prv_hs, prv_rvalid, outstanding, redir_now, hs_now;
    int          m_delay, ndeliv;

    initial begin
        reset = 1'b1; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
        BranchTargetE = '0; ResultW = '0;
        imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 0; imem_bus.imem_rdata = '0;

        //   rst stl fl br brt      pcs res     rdy rv rdata   chk req addr    vld instr  pc8
        row(1, 0, 0, 0, 0,      0, 0,      1, 0, 0,      0, 0, 0,      0, 0,     0);
        row(1, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 0, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'hA,    1, 0, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 8,      1, 'hA,   8);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'hB,    1, 0, 8,      0, 0,     8);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 16,     1, 'hB,   16);
        row(0, 1, 0, 0, 0,      0, 0,      1, 1, 'hC,    1, 0, 16,     0, 0,     16);
        row(0, 1, 0, 0, 0,      0, 0,      1, 0, 0,      1, 0, 16,     0, 0,     16);
        row(0, 1, 0, 0, 0,      0, 0,      1, 0, 0,      1, 0, 16,     0, 0,     16);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 0, 16,     0, 0,     16);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 24,     1, 'hC,   24);
        row(0, 0, 0, 1, 'h100,  0, 0,      1, 0, 0,      1, 0, 24,     0, 0,     24);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'hD,    1, 0, 'h100,  0, 0,     24);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 'h100,  0, 0,     24);
        row(0, 0, 0, 1, 'h100,  1, 'h200,  1, 1, 'hE,    1, 0, 'h100,  0, 0,     24);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 'h200,  0, 0,     24);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'hF,    1, 0, 'h200,  0, 0,     24);
        row(0, 0, 0, 0, 0,      0, 0,      0, 0, 0,      1, 1, 'h208,  1, 'hF,   'h208);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 'h208,  0, 0,     'h208);
        row(1, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 0, 'h208,  0, 0,     'h208);
        row(0, 0, 0, 0, 0,      0, 0,      0, 1, 'h77,   1, 1, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      0, 0, 0,      1, 1, 0,      0, 0,     0);
        row(0, 0, 0, 1, 'h300,  0, 0,      1, 0, 0,      1, 1, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'h55,   1, 0, 'h300,  0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 'h300,  0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'h66,   1, 0, 'h300,  0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      0, 0, 0,      1, 1, 'h308,  1, 'h66,  'h308);
        row(0, 0, 0, 1, TOP,    0, 0,      0, 0, 0,      1, 1, 'h308,  0, 0,     'h308);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, TOP,    0, 0,     'h308);
        row(0, 0, 0, 0, 0,      0, 0,      1, 1, 'h99,   1, 0, TOP,    0, 0,     'h308);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 0,      1, 'h99,  0);
        row(0, 0, 1, 0, 0,      0, 0,      1, 1, 'h42,   1, 0, 0,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      1, 0, 0,      1, 1, 8,      0, 0,     0);
        row(0, 1, 0, 0, 0,      0, 0,      1, 1, 'h11,   1, 0, 8,      0, 0,     0);
        row(0, 1, 0, 1, 'h400,  0, 0,      1, 0, 0,      1, 0, 8,      0, 0,     0);
        row(0, 0, 0, 0, 0,      0, 0,      0, 0, 0,      1, 1, 'h400,  0, 0,     0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            reset = vecs[i].rst[0]; StallD = vecs[i].stall[0]; FlushD = vecs[i].flush[0];
            BranchTakenE = vecs[i].br[0]; BranchTargetE = vecs[i].brt;
            PCSrcW = vecs[i].pcsrc[0]; ResultW = vecs[i].res;
            imem_bus.imem_ready = vecs[i].rdy[0]; imem_bus.imem_rvalid = vecs[i].rv[0];
            imem_bus.imem_rdata = vecs[i].rdata;
            @(negedge clk);
            if (vecs[i].chk[0]) begin
                chk($sformatf("vec%0d_req", i),   64'(imem_bus.imem_req), vecs[i].ereq);
                chk($sformatf("vec%0d_addr", i),  imem_bus.imem_addr,     vecs[i].eaddr);
                chk($sformatf("vec%0d_valid", i), 64'(ValidD),            vecs[i].evalid);
                chk($sformatf("vec%0d_instr", i), InstructionD,           vecs[i].einstr);
                chk($sformatf("vec%0d_pc8", i),   PCPlus8D,               vecs[i].epc8);
            end
        end

        // Randomized traffic: fresh reset, then a program-order model.
        @(posedge clk); #1;
        reset = 1'b1; StallD = 0; FlushD = 0; BranchTakenE = 0; PCSrcW = 0;
        imem_bus.imem_ready = 0; imem_bus.imem_rvalid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        exp_pc = '0; outstanding = 0; m_delay = 0; m_addr = '0; ndeliv = 0;
        prv_stall = 1; prv_redir = 0; prv_hs = 0; prv_rvalid = 0; prv_tgt = '0; prv_addr = '0;
        p_instr = '0; p_pc8 = '0; p_valid = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prv_stall) begin
                chk("rnd_stall_instr", InstructionD, p_instr);
                chk("rnd_stall_pc8",   PCPlus8D,     p_pc8);
                chk("rnd_stall_valid", 64'(ValidD),  64'(p_valid));
            end else if (prv_redir) begin
                chk("rnd_redir_bubble", 64'(ValidD), 64'd0);
                chk("rnd_redir_pc8",    PCPlus8D,    p_pc8);
            end else if (ValidD) begin
                chk("rnd_instr", InstructionD, mem_word(exp_pc));
                chk("rnd_pc8",   PCPlus8D,     exp_pc + 64'd8);
                exp_pc = exp_pc + 64'd8;
                ndeliv++;
            end else begin
                chk("rnd_bubble_instr", InstructionD, 64'd0);
                chk("rnd_bubble_pc8",   PCPlus8D,     p_pc8);
            end
            if (prv_redir) exp_pc = prv_tgt;

            if (prv_rvalid) outstanding = 0;
            if (prv_hs) begin
                outstanding = 1; m_addr = prv_addr; m_delay = $urandom % 3;
            end else if (outstanding && m_delay > 0) begin
                m_delay--;
            end

            StallD        = ($urandom % 4) == 0;
            BranchTakenE  = ($urandom % 12) == 0;
            PCSrcW        = ($urandom % 16) == 0;
            BranchTargetE = (64'($urandom_range(0, 4095)) << 3);
            ResultW       = (($urandom % 5) == 0) ? 64'hFFFF_FFFF_FFFF_FFE0 : (64'($urandom_range(0, 4095)) << 3);
            imem_bus.imem_ready  = ($urandom % 4) != 0;
            imem_bus.imem_rvalid = outstanding && (m_delay == 0);
            imem_bus.imem_rdata  = imem_bus.imem_rvalid ? mem_word(m_addr) : {$urandom, $urandom};
            redir_now = BranchTakenE | PCSrcW;
            tgt       = PCSrcW ? ResultW : BranchTargetE;

            @(negedge clk);
            if (outstanding) chk("rnd_single_outstanding", 64'(imem_bus.imem_req), 64'd0);
            hs_now = imem_bus.imem_req & imem_bus.imem_ready;
            if (hs_now && !redir_now) chk("rnd_req_addr", imem_bus.imem_addr, exp_pc);

            p_instr = InstructionD; p_pc8 = PCPlus8D; p_valid = ValidD;
            prv_stall = StallD; prv_redir = redir_now; prv_tgt = tgt;
            prv_hs = hs_now; prv_addr = imem_bus.imem_addr; prv_rvalid = imem_bus.imem_rvalid;
            @(posedge clk); #1;
        end

        nchk++;
        if (ndeliv < 100) begin
            nerr++;
            $display("FAIL rnd_progress: got %0d deliveries expected at least 100", ndeliv);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
